// File: rtl/req_arbiter_pkg.sv
// Shared types and constants for the request arbiter.
// Imported by the arbiter top and its pick sub-module.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/req_arbiter_if.sv
// Requester-side handshake bundle for req_arbiter.
// The master modport drives requests; the slave modport is the arbiter.
interface req_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);

  logic            mode;
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic            timeout_err;

  modport master (
    output mode, req, done,
    input  gnt, gnt_id, gnt_valid, timeout_err
  );

  modport slave (
    input  mode, req, done,
    output gnt, gnt_id, gnt_valid, timeout_err
  );

endinterface

// File: rtl/req_arbiter_pick.sv
// Combinational arbitration core: fixed-priority or round-robin winner select.
// Round-robin masks off requesters below rr_ptr and falls back to the full vector.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            mode,
  output logic [IDW-1:0]  win_id,
  output logic            win_any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] sel;

  // In fixed mode the mask is empty, so the unmasked lowest index wins.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      mask[i] = (mode == MODE_RR) && (i >= int'(rr_ptr));
    end
    masked = req & mask;
    sel    = (|masked) ? masked : req;
  end

  always_comb begin
    win_id = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (sel[i]) win_id = IDW'(i);
    end
    win_any = |req;
  end

endmodule

// File: rtl/req_arbiter.sv
// Single-resource arbiter: registered one-hot grant, held until done,
// request drop or hold-timer expiry, with a one-cycle turnaround between grants.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = $clog2(NREQ),
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  req_arbiter_if.slave bus
);

  localparam int unsigned HCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [HCW-1:0] HC_MAX = '1;

  arb_state_e      state, state_nx;
  logic [NREQ-1:0] gnt_r, gnt_nx;
  logic [IDW-1:0]  gnt_id_r, gnt_id_nx;
  logic            gnt_valid_r, gnt_valid_nx;
  logic            err_r, err_nx;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nx;
  logic [HCW-1:0]  hold_cnt, hold_cnt_nx;

  logic [IDW-1:0]  win_id;
  logic            win_any;
  logic            holder_req;
  logic            expire;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .mode    (bus.mode),
    .win_id  (win_id),
    .win_any (win_any)
  );

  assign holder_req = bus.req[gnt_id_r];
  assign expire     = (TIMEOUT != 0) && (hold_cnt == HCW'(TIMEOUT));

  // Next-state and registered-output computation.
  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt_r;
    gnt_id_nx    = gnt_id_r;
    gnt_valid_nx = gnt_valid_r;
    err_nx       = 1'b0;
    rr_ptr_nx    = rr_ptr;
    hold_cnt_nx  = hold_cnt;

    case (state)
      ARB_IDLE: begin
        gnt_nx       = '0;
        gnt_valid_nx = 1'b0;
        hold_cnt_nx  = '0;
        if (win_any) begin
          state_nx     = ARB_GRANT;
          gnt_nx       = NREQ'(1) << win_id;
          gnt_id_nx    = win_id;
          gnt_valid_nx = 1'b1;
          hold_cnt_nx  = HCW'(1);
          if (bus.mode == MODE_RR) begin
            rr_ptr_nx = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
          end
        end
      end

      ARB_GRANT: begin
        if (bus.done || !holder_req || expire) begin
          state_nx     = ARB_IDLE;
          gnt_nx       = '0;
          gnt_valid_nx = 1'b0;
          hold_cnt_nx  = '0;
          // The error flags only a pure timer release.
          err_nx       = expire && !bus.done && holder_req;
        end else if (hold_cnt != HC_MAX) begin
          hold_cnt_nx = hold_cnt + HCW'(1);
        end
      end

      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARB_IDLE;
      gnt_r       <= '0;
      gnt_id_r    <= '0;
      gnt_valid_r <= 1'b0;
      err_r       <= 1'b0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nx;
      gnt_r       <= gnt_nx;
      gnt_id_r    <= gnt_id_nx;
      gnt_valid_r <= gnt_valid_nx;
      err_r       <= err_nx;
      rr_ptr      <= rr_ptr_nx;
      hold_cnt    <= hold_cnt_nx;
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.gnt_id      = gnt_id_r;
  assign bus.gnt_valid   = gnt_valid_r;
  assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the grant rules.
module tb_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [N-1:0] req;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Reference model state: who holds the resource and for how long.
  int   m_busy, m_id, m_cnt, m_ptr;
  logic m_err;

  always #5 clk = ~clk;

  req_arbiter_if #(.NREQ(N)) bus ();

  assign bus.mode = mode;
  assign bus.req  = req;
  assign bus.done = done;

  req_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [N-1:0] exp_gnt();
    return (m_busy != 0) ? (N'(1) << m_id) : '0;
  endfunction

  task automatic model_step();
    int  w;
    int  idx;
    bit  exp_t;
    if (!rst) begin
      m_busy = 0; m_id = 0; m_cnt = 0; m_ptr = 0; m_err = 1'b0;
    end else if (m_busy == 0) begin
      m_err = 1'b0;
      if (req != '0) begin
        w = -1;
        for (int j = 0; j < int'(N); j++) begin
          idx = (mode == 1'b0) ? j : (m_ptr + j) % int'(N);
          if (w < 0 && req[idx]) w = idx;
        end
        m_busy = 1;
        m_id   = w;
        m_cnt  = 1;
        if (mode) m_ptr = (w + 1) % int'(N);
      end
    end else begin
      exp_t = (TO != 0) && (m_cnt == int'(TO));
      if (done || !req[m_id] || exp_t) begin
        m_err  = exp_t && !done && req[m_id];
        m_busy = 0;
        m_cnt  = 0;
      end else begin
        m_err = 1'b0;
        m_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 1'b0; done = 1'b0; req = 4'b1111;
    tick(); tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.gnt_valid); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.timeout_err); end
    total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d exp=0", bus.gnt_id); end
    rst = 1'b1;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", bus.gnt); end
    req = 4'b0000;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_drop_gnt got=%b exp=0000", bus.gnt); end
  endtask

  task automatic test_fixed();
    mode = 1'b0; req = 4'b1100;
    tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL fixed_gnt got=%b exp=0100", bus.gnt); end
    total++; if (bus.gnt_id !== 2'd2) begin bad++; $display("FAIL fixed_id got=%0d exp=2", bus.gnt_id); end
    done = 1'b1;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL fixed_gap got=%b exp=0000", bus.gnt); end
    done = 1'b0; req = 4'b1000;
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL fixed_gnt3 got=%b exp=1000", bus.gnt); end
    total++; if (bus.gnt_id !== 2'd3) begin bad++; $display("FAIL fixed_id3 got=%0d exp=3", bus.gnt_id); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    mode = 1'b1; req = 4'b1111; done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      e = N'(1) << (k % 4);
      total++; if (bus.gnt !== e) begin bad++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, bus.gnt, e); end
      total++; if (bus.gnt_id !== 2'(k % 4)) begin bad++; $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, bus.gnt_id, k % 4); end
      done = 1'b1;
      tick();
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rr_gap k=%0d got=%b exp=0000", k, bus.gnt); end
      done = 1'b0;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int held;
    mode = 1'b0; req = 4'b0010; done = 1'b0;
    tick();
    held = 0;
    for (int c = 0; c < 40 && bus.gnt_valid; c++) begin
      total++; if (bus.gnt !== 4'b0010 || bus.timeout_err !== 1'b0) begin
        bad++; $display("FAIL to_hold c=%0d gnt=%b err=%b exp gnt=0010 err=0", c, bus.gnt, bus.timeout_err);
      end
      held++;
      tick();
    end
    total++; if (held != int'(TO)) begin bad++; $display("FAIL to_len got=%0d exp=%0d", held, TO); end
    total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.timeout_err); end
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL to_gnt got=%b exp=0000", bus.gnt); end
    tick();
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", bus.timeout_err); end
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL to_regrant got=%b exp=0010", bus.gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_collision();
    mode = 1'b0; req = 4'b0010; done = 1'b0;
    tick();
    repeat (TO - 1) tick();
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL col_hold got=%b exp=0010", bus.gnt); end
    done = 1'b1;
    tick();
    total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL col_gnt got=%b exp=0000", bus.gnt); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL col_err got=%b exp=0", bus.timeout_err); end
    done = 1'b0; req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL drop_gnt got=%b exp=0100", bus.gnt); end
    req = 4'b0000;
    tick();
    total++; if (bus.gnt !== 4'b0000 || bus.timeout_err !== 1'b0) begin
      bad++; $display("FAIL drop_rel gnt=%b err=%b exp gnt=0000 err=0", bus.gnt, bus.timeout_err);
    end
  endtask

  task automatic test_reset_mid_grant();
    mode = 1'b0; req = 4'b0100; done = 1'b0;
    tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL rmid_gnt got=%b exp=0100", bus.gnt); end
    rst = 1'b0; req = 4'b1111;
    tick();
    total++; if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++; $display("FAIL rmid_drop gnt=%b valid=%b err=%b exp 0000/0/0", bus.gnt, bus.gnt_valid, bus.timeout_err);
    end
    rst = 1'b1; mode = 1'b1;
    tick();
    total++; if (bus.gnt_id !== 2'd0 || bus.gnt !== 4'b0001) begin
      bad++; $display("FAIL rmid_ptr id=%0d gnt=%b exp id=0 gnt=0001", bus.gnt_id, bus.gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom_range(0, 79) != 0);
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      done = ($urandom_range(0, 15) == 0);
      tick();
      total++; if (bus.gnt !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt()); end
      total++; if (bus.gnt_valid !== (m_busy != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, bus.gnt_valid, m_busy); end
      total++; if (bus.timeout_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, bus.timeout_err, m_err); end
      if (m_busy != 0) begin
        total++; if (bus.gnt_id !== 2'(m_id)) begin bad++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, bus.gnt_id, m_id); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; mode = 1'b0; req = '0; done = 1'b0;
    m_busy = 0; m_id = 0; m_cnt = 0; m_ptr = 0; m_err = 1'b0;
    #2;
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
